instruction_fetch: RTL
======================

# instruction_fetch

Instruction Fetch stage: owns the program counter and drives the synchronous program memory read port. It presents a 32-bit instruction word and a 14-bit return address directly to the IF/ID pipeline register inputs (`instruction_in`, `return_addr_in`). It handles stalls, branch/jump redirects and post-reset fill, and inserts NOP bubbles where no valid instruction exists.

## Interface
- `ADDR_WIDTH`, 14: program counter and instruction memory address width; fixed at 14 to match IF/ID.
- `RESET_VECTOR`, 14'h0000: PC value loaded on reset.
- `NOP_WORD`, 32'h00000000: instruction word emitted for bubbles.

Ports:
- `clock` in 1: system clock, all state on the rising edge.
- `nreset` in 1: reset, synchronous, active-low; clock `clock`.
- `stall` in 1: hazard stall. It is the same signal that freezes IF/ID.
- `redirect` in 1: taken branch/jump from a downstream stage; one-cycle pulse.
- `redirect_addr` in 14: target PC, sampled when `redirect`=1.
- `imem_addr` out 14: program memory read address, registered PC.
- `imem_en` out 1: program memory read enable.
- `imem_rdata` in 32: memory read data, valid the cycle after an enabled read edge.
- `instruction_out` out 32: instruction to IF/ID.
- `return_addr_out` out 14: address of `instruction_out` + 1, to IF/ID.
- `fetch_valid` out 1: 1 when `instruction_out` is a real fetched instruction, not a bubble.

## Operation
Registers:
- `pc`: next address to read.
- `resp_pc`: address whose data is currently on `imem_rdata`.
- `hold_instr`: 32-bit instruction captured at stall entry.
- `state`: one of BUBBLE, RUN, HOLD.

Combinational outputs:
- `imem_addr` = `pc`.
- `imem_en` = ~`stall` & ~`redirect`.
- `instruction_out`:
  - `NOP_WORD` if `redirect`=1 or `state`=BUBBLE;
  - otherwise `imem_rdata` in RUN and `hold_instr` in HOLD.
- `return_addr_out`: 0 when bubble, else `resp_pc`+1.
- `fetch_valid` = ~`redirect` & (`state`≠BUBBLE).

Transitions, evaluated in priority order:
1. `nreset`=0: `pc`←`RESET_VECTOR`, `resp_pc`←0, `hold_instr`←`NOP_WORD`, `state`←BUBBLE.
2. `redirect`=1, any state, regardless of `stall`: `pc`←`redirect_addr`, `state`←BUBBLE.
3. `stall`=1:
   - RUN: `hold_instr`←`imem_rdata`, `state`←HOLD.
   - BUBBLE and HOLD: no change.
4. `stall`=0, any state: `resp_pc`←`pc`, `pc`←`pc`+1, `state`←RUN.

Arithmetic rules:
- `pc`+1 and `resp_pc`+1 are modulo 2^14. 14'h3FFF wraps to 14'h0000.
- `redirect_addr` is used verbatim; it carries no alignment or offset.

Boundary conditions:
- Redirect during stall: the redirect wins and the stall is ignored for that edge.
- Reset during redirect or stall: reset wins.
- Stall in BUBBLE: NOPs continue and the PC is frozen.
- `hold_instr` is only loaded on the RUN→HOLD edge. The memory is not required to hold its output while disabled.

## Timing
- Reset values of all outputs (cycle after the reset edge):
  - `instruction_out` = `NOP_WORD`, `return_addr_out` = 0, `fetch_valid` = 0;
  - `imem_addr` = `RESET_VECTOR`; `imem_en` = ~`stall`.
- Fill latency: the first reset-release cycle without stall is BUBBLE. The next cycle presents mem[`RESET_VECTOR`] with `return_addr_out` = `RESET_VECTOR`+1.
- Steady state: one instruction per cycle, in sequential addresses.
- Redirect penalty: the redirect cycle and the following cycle both output NOP (`fetch_valid`=0). The target instruction appears 2 cycles after the redirect cycle, assuming no stall.
- Stall:
  - The instruction presented in the first stall cycle is presented unchanged every cycle until the stall drops.
  - It is still presented in the release cycle, so IF/ID captures it on the release edge.
  - The next sequential instruction follows one cycle later. No instruction is lost or duplicated.

## Test plan
- **Reset/fill:** release reset with `RESET_VECTOR`=0x0010 and mem[0x10]=0xA5A50001.
  - Cycle 0: NOP, `fetch_valid`=0.
  - Cycle 1: 0xA5A50001, `return_addr_out`=0x0011.
- **Sequential fetch:** memory word = address. Outputs are 0x10, 0x11, 0x12 on consecutive cycles, with `imem_addr` one ahead.
- **Stall:** assert `stall` for 3 cycles while 0x12 is output.
  - 0x12 is held for 4 cycles and `imem_en`=0 during the stall.
  - 0x13 follows the release cycle.
  - Corrupting `imem_rdata` during the stall has no effect.
- **Redirect:** pulse `redirect` with `redirect_addr`=0x0200 mid-stream.
  - Two NOP cycles, then 0x200 with `return_addr_out`=0x0201.
  - Repeat with `stall`=1 in the redirect cycle: same result.
- **Wrap:** redirect to 0x3FFF. The output is 0x3FFF with `return_addr_out`=0x0000, then the instruction at 0x0000.
- **Reset mid-stall/redirect:** assert `nreset`=0 while in HOLD and with `redirect`=1.
  - Next cycle is BUBBLE with `imem_addr`=`RESET_VECTOR`.
  - `hold_instr` is discarded and never output.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous program memory read port and
// presents instruction / return address to IF/ID, inserting NOP bubbles where nothing is valid.
module instruction_fetch #(
    parameter int unsigned            ADDR_WIDTH   = 14,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [31:0]            NOP_WORD     = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_en,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instruction_out,
    output logic [ADDR_WIDTH-1:0] return_addr_out,
    output logic                  fetch_valid
);

    typedef enum logic [1:0] {StBubble, StRun, StHold} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [31:0]           hold_instr_q, hold_instr_d;
    logic                  bubble;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q      <= StBubble;
            pc_q         <= RESET_VECTOR;
            resp_pc_q    <= '0;
            hold_instr_q <= NOP_WORD;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Redirect beats stall; a stall only captures data on the RUN->HOLD edge because the
    // memory output is not guaranteed while the read port is disabled.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        hold_instr_d = hold_instr_q;
        if (redirect) begin
            pc_d    = redirect_addr;
            state_d = StBubble;
        end else if (stall) begin
            if (state_q == StRun) begin
                hold_instr_d = imem_rdata;
                state_d      = StHold;
            end
        end else begin
            resp_pc_d = pc_q;
            pc_d      = pc_q + ADDR_WIDTH'(1);
            state_d   = StRun;
        end
    end

    always_comb begin
        bubble          = redirect | (state_q == StBubble);
        imem_addr       = pc_q;
        imem_en         = ~stall & ~redirect;
        fetch_valid     = ~bubble;
        instruction_out = NOP_WORD;
        return_addr_out = '0;
        if (!bubble) begin
            instruction_out = (state_q == StHold) ? hold_instr_q : imem_rdata;
            return_addr_out = resp_pc_q + ADDR_WIDTH'(1);
        end
    end

endmodule
